ram_copy_engine: RTL and testbench

Single-port memory-copy initiator for the processor's synchronous `RAM` block: given a source address, destination address and word count, it drives the RAM's `wEn`/`addr`/`dataIn` port and consumes `dataOut` to copy a block of words inside the same RAM. The engine sits between a control source (processor MMIO or a test harness) and the RAM port, owning that port while `busy` is high. Each word costs one read cycle and one write cycle. Overlapping ranges are handled by choosing the copy direction.

---
 rtl/ram_copy_engine.sv | 152 +++++++++++++++
 tb/tb_ram_copy_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: copies a block of words inside one synchronous single-port RAM (memmove semantics).
// Latency: 2N+1 cycles from accepted start to the done pulse (one READ and one WRITE per word; 1 cycle for N=0).
// Backpressure: none; owns the RAM port while busy, and ignores start outside IDLE. Optional RAM_COPY_CHECKSUM_EN adds a running sum.
module ram_copy_engine #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] src_addr,
    input  logic [ADDRESS_WIDTH-1:0] dst_addr,
    input  logic [ADDRESS_WIDTH-1:0] length,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    checksum,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_src;
    logic [ADDRESS_WIDTH-1:0] r_dst;
    logic [ADDRESS_WIDTH-1:0] r_remain;
    logic                     r_desc;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_wen;
    logic [ADDRESS_WIDTH-1:0] r_addr;

    logic [ADDRESS_WIDTH-1:0] w_diff;
    logic                     w_desc;
    logic [ADDRESS_WIDTH-1:0] w_first;
    logic [ADDRESS_WIDTH-1:0] w_src_first;
    logic [ADDRESS_WIDTH-1:0] w_dst_first;
    logic [ADDRESS_WIDTH-1:0] w_src_next;
    logic [ADDRESS_WIDTH-1:0] w_dst_next;

    // Destination landing inside the source window ahead of it means an
    // ascending copy would clobber unread words, so walk from the top down.
    assign w_diff      = dst_addr - src_addr;
    assign w_desc      = (w_diff != '0) && (w_diff < length);
    assign w_first     = w_desc ? (length - ONE) : '0;
    assign w_src_first = src_addr + w_first;
    assign w_dst_first = dst_addr + w_first;
    assign w_src_next  = r_desc ? (r_src - ONE) : (r_src + ONE);
    assign w_dst_next  = r_desc ? (r_dst - ONE) : (r_dst + ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_remain <= '0;
            r_desc   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wen    <= 1'b0;
            r_addr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_wen  <= 1'b0;
                    r_addr <= '0;
                    if (start) begin
                        if (length == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= S_READ;
                            r_busy   <= 1'b1;
                            r_desc   <= w_desc;
                            r_src    <= w_src_first;
                            r_dst    <= w_dst_first;
                            r_remain <= length;
                            r_addr   <= w_src_first;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_WRITE;
                    r_wen   <= 1'b1;
                    r_addr  <= r_dst;
                end
                S_WRITE: begin
                    r_wen <= 1'b0;
                    if (r_remain == ONE) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_addr  <= '0;
                    end else begin
                        r_state  <= S_READ;
                        r_src    <= w_src_next;
                        r_dst    <= w_dst_next;
                        r_addr   <= w_src_next;
                        r_remain <= r_remain - ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_wen   <= 1'b0;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign ram_wEn  = r_wen;
    assign ram_addr = r_addr;
    // Read data arrives in the WRITE cycle itself and is forwarded straight back.
    assign ram_dataIn = (r_state == S_WRITE) ? ram_dataOut : '0;

`ifdef RAM_COPY_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_checksum <= '0;
        end else if (r_state == S_WRITE) begin
            r_checksum <= r_checksum + ram_dataOut;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: synchronous RAM model plus a memmove-style reference that predicts
// the per-cycle port trace and the final memory image, with randomized copies on top of directed ones.
module tb_ram_copy_engine;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] src_addr, dst_addr, length;
    logic          busy, done, ram_wEn;
    logic [DW-1:0] checksum, ram_dataIn, ram_dataOut;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] mem     [0:DEPTH-1];
    logic [DW-1:0] exp_mem [0:DEPTH-1];

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          chk_vld;
        logic [DW-1:0] chk;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    ram_copy_engine #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .checksum(checksum),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr),
        .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
    );

    always @(posedge clk) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (rst_n && exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("busy", 64'(busy), 64'(r.busy));
            chk("done", 64'(done), 64'(r.done));
            chk("ram_wEn", 64'(ram_wEn), 64'(r.wen));
            chk("ram_addr", 64'(ram_addr), 64'(r.addr));
            if (r.wen || !r.busy) chk("ram_dataIn", 64'(ram_dataIn), 64'(r.din));
            if (r.chk_vld) chk("checksum", 64'(checksum), 64'(r.chk));
        end
    end

    function automatic rec_t mk(input logic b, input logic d, input logic w,
                                input int a, input logic [DW-1:0] din,
                                input logic cv, input logic [DW-1:0] c);
        rec_t r;
        r.busy = b; r.done = d; r.wen = w; r.addr = AW'(a % DEPTH);
        r.din = din; r.chk_vld = cv; r.chk = c;
        return r;
    endfunction

    // Expected port trace from cycle 1 on, plus memmove applied to exp_mem.
    // Only the first n_keep cycles are queued; writes after that are not applied.
    task automatic gen_trace(input int src, input int dst, input int n, input int n_keep);
        logic [DW-1:0] vals[$];
        logic [DW-1:0] sum, sum_exp;
        int diff, cyc, i;
        bit desc;
        sum = '0;
        cyc = 0;
        diff = (dst - src + DEPTH) % DEPTH;
        desc = (n > 0) && (diff >= 1) && (diff <= n - 1);
        for (int k = 0; k < n; k++) begin
            vals.push_back(exp_mem[(src + k) % DEPTH]);
            sum += exp_mem[(src + k) % DEPTH];
        end
`ifdef RAM_COPY_CHECKSUM_EN
        sum_exp = sum;
`else
        sum_exp = '0;
`endif
        for (int k = 0; k < n; k++) begin
            i = desc ? (n - 1 - k) : k;
            if (cyc < n_keep) exp_q.push_back(mk(1, 0, 0, src + i, '0, 0, '0));
            cyc++;
            if (cyc < n_keep) begin
                exp_q.push_back(mk(1, 0, 1, dst + i, vals[i], 0, '0));
                exp_mem[(dst + i) % DEPTH] = vals[i];
            end
            cyc++;
        end
        if (cyc < n_keep) exp_q.push_back(mk(0, 1, 0, 0, '0, 1, sum_exp));
        cyc++;
        if (cyc < n_keep) exp_q.push_back(mk(0, 0, 0, 0, '0, 1, sum_exp));
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        chk("trace_drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk(name, 64'(bad), 64'd0);
    endtask

    task automatic poke(input int a, input logic [DW-1:0] v);
        mem[a] = v;
        exp_mem[a] = v;
    endtask

    task automatic run_copy(input int src, input int dst, input int n);
        @(negedge clk);
        start = 1'b1;
        src_addr = AW'(src); dst_addr = AW'(dst); length = AW'(n);
        @(posedge clk);
        #1 start = 1'b0;
        gen_trace(src, dst, n, 1 << 20);
        wait_drain();
    endtask

    initial begin
        logic [DW-1:0] saved22, saved23;
        int s, d, n;
        rst_n = 1'b0; start = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0;
        for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_wEn", 64'(ram_wEn), 64'd0);
        chk("reset_addr", 64'(ram_addr), 64'd0);
        chk("reset_dataIn", 64'(ram_dataIn), 64'd0);
        chk("reset_checksum", 64'(checksum), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic copy
        poke(0, 32'h11); poke(1, 32'h22); poke(2, 32'h33); poke(3, 32'h44);
        run_copy(0, 10, 4);
        chk("basic_m10", 64'(mem[10]), 64'h11);
        chk("basic_m11", 64'(mem[11]), 64'h22);
        chk("basic_m12", 64'(mem[12]), 64'h33);
        chk("basic_m13", 64'(mem[13]), 64'h44);
        chk("basic_src_kept", 64'(mem[0]), 64'h11);
        check_mem("basic_mem");

        // Zero length
        run_copy(5, 6, 0);
        check_mem("zero_mem");

        // Overlap, descending
        for (int i = 0; i < 6; i++) poke(i, DW'(i + 1));
        run_copy(0, 2, 4);
        for (int i = 0; i < 6; i++) begin
            logic [DW-1:0] want;
            want = (i < 2) ? DW'(i + 1) : DW'(i - 1);
            chk($sformatf("overlap_m%0d", i), 64'(mem[i]), 64'(want));
        end

        // Wrap-around
        poke(4094, 32'hA); poke(4095, 32'hB); poke(0, 32'hC);
        run_copy(4094, 100, 3);
        chk("wrap_m100", 64'(mem[100]), 64'hA);
        chk("wrap_m101", 64'(mem[101]), 64'hB);
        chk("wrap_m102", 64'(mem[102]), 64'hC);

        // Checksum with carry-out wrap
        poke(200, 32'd1); poke(201, 32'd2); poke(202, 32'd3); poke(203, 32'hFFFF_FFFF);
        run_copy(200, 300, 4);
`ifdef RAM_COPY_CHECKSUM_EN
        chk("checksum_hold", 64'(checksum), 64'h5);
`else
        chk("checksum_hold", 64'(checksum), 64'h0);
`endif

        // Back-to-back with start held through DONE
        @(negedge clk);
        start = 1'b1; src_addr = 12'd400; dst_addr = 12'd402; length = 12'd3;
        @(posedge clk);
        #1;
        gen_trace(400, 402, 3, 1 << 20);
        gen_trace(400, 402, 3, 1 << 20);
        repeat (2 * 3 + 2) @(posedge clk);
        #1 start = 1'b0;
        wait_drain();
        check_mem("b2b_mem");

        // Ignored restart, then reset during the third word
        poke(0, 32'h51); poke(1, 32'h52); poke(2, 32'h53); poke(3, 32'h54);
        saved22 = mem[22]; saved23 = mem[23];
        @(negedge clk);
        start = 1'b1; src_addr = 12'd0; dst_addr = 12'd20; length = 12'd4;
        @(posedge clk);
        #1 start = 1'b0;
        gen_trace(0, 20, 4, 4);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; dst_addr = 12'd50; length = 12'd2;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_wEn", 64'(ram_wEn), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_addr", 64'(ram_addr), 64'd0);
        chk("rst_mid_queue", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_m20", 64'(mem[20]), 64'h51);
        chk("rst_m21", 64'(mem[21]), 64'h52);
        chk("rst_m22_untouched", 64'(mem[22]), 64'(saved22));
        chk("rst_m23_untouched", 64'(mem[23]), 64'(saved23));
        check_mem("rst_mem");

        // Randomized copies
        for (int t = 0; t < 25; t++) begin
            s = int'($urandom_range(0, DEPTH - 1));
            n = int'($urandom_range(0, 40));
            if ($urandom_range(0, 1) == 1) d = (s + int'($urandom_range(0, 8)) - 4 + DEPTH) % DEPTH;
            else d = int'($urandom_range(0, DEPTH - 1));
            run_copy(s, d, n);
        end
        check_mem("random_mem");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
